// File: rtl/pr_region_pkg.sv
// Shared constants for the PR region filter: filter mode codes and the
// field order of the packed line-buffer word (field 0 is the MSB field).
package pr_region_pkg;
  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_GRAY = 3'd1;
  localparam logic [2:0] MODE_INV  = 3'd2;
  localparam logic [2:0] MODE_THR  = 3'd3;
  localparam logic [2:0] MODE_EDGE = 3'd4;
  localparam logic [2:0] MODE_BLUR = 3'd5;

  localparam int F_GRAY  = 0;
  localparam int F_LEFT  = 1;
  localparam int F_RIGHT = 2;
  localparam int F_UP    = 3;
  localparam int F_DOWN  = 4;
  localparam int F_LU    = 5;
  localparam int F_LD    = 6;
  localparam int F_RU    = 7;
  localparam int F_RD    = 8;
  localparam int F_BLUE  = 9;
  localparam int F_GREEN = 10;
  localparam int F_RED   = 11;
  localparam int NFIELD  = 12;
endpackage

// File: rtl/pr_kernel3x3.sv
// Combinational 3x3 kernels on the gray neighbourhood: Sobel gx/gy and a
// 1-2-4 Gaussian sum (unnormalised).
module pr_kernel3x3 #(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0]        i_c,
  input  logic [IN_W-1:0]        i_l,
  input  logic [IN_W-1:0]        i_r,
  input  logic [IN_W-1:0]        i_u,
  input  logic [IN_W-1:0]        i_d,
  input  logic [IN_W-1:0]        i_lu,
  input  logic [IN_W-1:0]        i_ld,
  input  logic [IN_W-1:0]        i_ru,
  input  logic [IN_W-1:0]        i_rd,
  output logic signed [IN_W+2:0] o_gx,
  output logic signed [IN_W+2:0] o_gy,
  output logic [IN_W+3:0]        o_gauss
);
  localparam int GW = IN_W + 3;
  localparam int GA = IN_W + 4;

  // Each weighted column/row sum is at most 4*(2^IN_W-1), so the
  // difference never leaves the signed GW-bit range.
  logic [GW-1:0] w_xp, w_xn, w_yp, w_yn;

  assign w_xp = GW'(i_ru) + (GW'(i_r) << 1) + GW'(i_rd);
  assign w_xn = GW'(i_lu) + (GW'(i_l) << 1) + GW'(i_ld);
  assign w_yp = GW'(i_ld) + (GW'(i_d) << 1) + GW'(i_rd);
  assign w_yn = GW'(i_lu) + (GW'(i_u) << 1) + GW'(i_ru);

  assign o_gx = $signed(w_xp - w_xn);
  assign o_gy = $signed(w_yp - w_yn);

  assign o_gauss = (GA'(i_c) << 2)
                 + ((GA'(i_l) + GA'(i_r) + GA'(i_u) + GA'(i_d)) << 1)
                 + GA'(i_lu) + GA'(i_ld) + GA'(i_ru) + GA'(i_rd);
endmodule

// File: rtl/pr_region_filter.sv
// Two-stage pixel pipeline: selectable filter applied inside a rectangular
// window, frame-synchronous mode switching, OUT_W-bit RGB to the VGA port.
module pr_region_filter
  import pr_region_pkg::*;
#(
  parameter int X0     = 100,
  parameter int X1     = 260,
  parameter int Y0     = 100,
  parameter int Y1     = 215,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4,
  parameter int THRESH = 128
) (
  input  logic                   pixel_clk,
  input  logic                   reset,
  input  logic                   blank,
  input  logic [9:0]             hc,
  input  logic [9:0]             vc,
  input  logic [12*IN_W-1:0]     dout,
  input  logic [2:0]             mode_req,
  input  logic                   mode_req_valid,
  output logic [OUT_W-1:0]       redx,
  output logic [OUT_W-1:0]       greenx,
  output logic [OUT_W-1:0]       bluex,
  output logic                   blank_d,
  output logic [9:0]             hc_d,
  output logic [9:0]             vc_d,
  output logic [2:0]             mode_active
);
  localparam int GW = IN_W + 3;
  localparam int GA = IN_W + 4;
  localparam logic [10:0] LX0 = 11'(X0);
  localparam logic [10:0] LX1 = 11'(X1);
  localparam logic [10:0] LY0 = 11'(Y0);
  localparam logic [10:0] LY1 = 11'(Y1);

  logic [IN_W-1:0] w_f [NFIELD];
  for (genvar k = 0; k < NFIELD; k++) begin : g_unpack
    assign w_f[k] = dout[(NFIELD-k)*IN_W-1 -: IN_W];
  end

  logic w_in_win, w_frame_start;
  assign w_in_win = !blank && ({1'b0, hc} >= LX0) && ({1'b0, hc} < LX1)
                           && ({1'b0, vc} >= LY0) && ({1'b0, vc} < LY1);
  assign w_frame_start = (hc == 10'd0) && (vc == 10'd0);

  // The frame-start pixel already carries the new mode, so a frame is
  // rendered entirely in one mode.
  logic [2:0] r_mode_active, r_mode_pend, w_mode_nxt;
  logic       r_pend_flag;

  always_comb begin
    w_mode_nxt = r_mode_active;
    if (w_frame_start) begin
      if (mode_req_valid)   w_mode_nxt = mode_req;
      else if (r_pend_flag) w_mode_nxt = r_mode_pend;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_mode_active <= '0;
      r_mode_pend   <= '0;
      r_pend_flag   <= 1'b0;
    end else begin
      r_mode_active <= w_mode_nxt;
      if (mode_req_valid) r_mode_pend <= mode_req;
      if (w_frame_start)       r_pend_flag <= 1'b0;
      else if (mode_req_valid) r_pend_flag <= 1'b1;
    end
  end

  assign mode_active = r_mode_active;

  logic signed [GW-1:0] w_gx, w_gy;
  logic [GA-1:0]        w_gauss;

  pr_kernel3x3 #(.IN_W(IN_W)) u_kernel (
    .i_c    (w_f[F_GRAY]),
    .i_l    (w_f[F_LEFT]),
    .i_r    (w_f[F_RIGHT]),
    .i_u    (w_f[F_UP]),
    .i_d    (w_f[F_DOWN]),
    .i_lu   (w_f[F_LU]),
    .i_ld   (w_f[F_LD]),
    .i_ru   (w_f[F_RU]),
    .i_rd   (w_f[F_RD]),
    .o_gx   (w_gx),
    .o_gy   (w_gy),
    .o_gauss(w_gauss)
  );

  logic                 r_s1_win, r_s1_blank;
  logic [2:0]           r_s1_mode;
  logic [IN_W-1:0]      r_s1_gray, r_s1_red, r_s1_green, r_s1_blue;
  logic signed [GW-1:0] r_s1_gx, r_s1_gy;
  logic [GA-1:0]        r_s1_gauss;
  logic [9:0]           r_s1_hc, r_s1_vc;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_s1_win   <= 1'b0;
      r_s1_blank <= 1'b0;
      r_s1_mode  <= '0;
      r_s1_gray  <= '0;
      r_s1_red   <= '0;
      r_s1_green <= '0;
      r_s1_blue  <= '0;
      r_s1_gx    <= '0;
      r_s1_gy    <= '0;
      r_s1_gauss <= '0;
      r_s1_hc    <= '0;
      r_s1_vc    <= '0;
    end else begin
      r_s1_win   <= w_in_win;
      r_s1_blank <= blank;
      r_s1_mode  <= w_mode_nxt;
      r_s1_gray  <= w_f[F_GRAY];
      r_s1_red   <= w_f[F_RED];
      r_s1_green <= w_f[F_GREEN];
      r_s1_blue  <= w_f[F_BLUE];
      r_s1_gx    <= w_gx;
      r_s1_gy    <= w_gy;
      r_s1_gauss <= w_gauss;
      r_s1_hc    <= hc;
      r_s1_vc    <= vc;
    end
  end

  logic [GW-1:0]   w_agx, w_agy;
  logic [GW:0]     w_esum;
  logic [IN_W-1:0] w_edge, w_blur, w_thr, w_vr, w_vg, w_vb;

  assign w_agx  = r_s1_gx[GW-1] ? $unsigned(-r_s1_gx) : $unsigned(r_s1_gx);
  assign w_agy  = r_s1_gy[GW-1] ? $unsigned(-r_s1_gy) : $unsigned(r_s1_gy);
  assign w_esum = {1'b0, w_agx} + {1'b0, w_agy};
  assign w_edge = (|w_esum[GW:IN_W]) ? '1 : w_esum[IN_W-1:0];
  assign w_blur = r_s1_gauss[GA-1:4];
  assign w_thr  = (r_s1_gray >= IN_W'(THRESH)) ? '1 : '0;

  always_comb begin
    w_vr = r_s1_red;
    w_vg = r_s1_green;
    w_vb = r_s1_blue;
    case (r_s1_mode)
      MODE_GRAY: begin w_vr = r_s1_gray; w_vg = r_s1_gray; w_vb = r_s1_gray; end
      MODE_INV:  begin w_vr = ~r_s1_red; w_vg = ~r_s1_green; w_vb = ~r_s1_blue; end
      MODE_THR:  begin w_vr = w_thr;  w_vg = w_thr;  w_vb = w_thr;  end
      MODE_EDGE: begin w_vr = w_edge; w_vg = w_edge; w_vb = w_edge; end
      MODE_BLUR: begin w_vr = w_blur; w_vg = w_blur; w_vb = w_blur; end
      default: ;
    endcase
    if (!r_s1_win) begin
      w_vr = '0;
      w_vg = '0;
      w_vb = '0;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      redx    <= '0;
      greenx  <= '0;
      bluex   <= '0;
      blank_d <= 1'b1;
      hc_d    <= '0;
      vc_d    <= '0;
    end else begin
      redx    <= w_vr[IN_W-1 -: OUT_W];
      greenx  <= w_vg[IN_W-1 -: OUT_W];
      bluex   <= w_vb[IN_W-1 -: OUT_W];
      blank_d <= r_s1_blank;
      hc_d    <= r_s1_hc;
      vc_d    <= r_s1_vc;
    end
  end
endmodule

// File: tb/tb_pr_region_filter.sv
// Scoreboard bench: directed pixels push hand-computed expectations; a
// negedge monitor pops each one two clocks after its pixel was applied.
module tb_pr_region_filter;
  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b1;
  logic [9:0]  hc = '0, vc = '0;
  logic [95:0] dout = '0;
  logic [2:0]  mode_req = '0;
  logic        mode_req_valid = 1'b0;
  logic [3:0]  redx, greenx, bluex;
  logic        blank_d;
  logic [9:0]  hc_d, vc_d;
  logic [2:0]  mode_active;
  logic [3:0]  e_redx, e_greenx, e_bluex;
  logic        e_blank_d;
  logic [9:0]  e_hc_d, e_vc_d;
  logic [2:0]  e_mode_active;

  pr_region_filter dut (
    .pixel_clk(pixel_clk), .reset(reset), .blank(blank), .hc(hc), .vc(vc),
    .dout(dout), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .redx(redx), .greenx(greenx), .bluex(bluex), .blank_d(blank_d),
    .hc_d(hc_d), .vc_d(vc_d), .mode_active(mode_active)
  );

  // Degenerate window (X0 >= X1): every output pixel must be black.
  pr_region_filter #(.X0(200), .X1(100)) dut_empty (
    .pixel_clk(pixel_clk), .reset(reset), .blank(blank), .hc(hc), .vc(vc),
    .dout(dout), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .redx(e_redx), .greenx(e_greenx), .bluex(e_bluex), .blank_d(e_blank_d),
    .hc_d(e_hc_d), .vc_d(e_vc_d), .mode_active(e_mode_active)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] r, g, b;
    logic       bl;
    logic [9:0] h, v;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   vid = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  always @(negedge pixel_clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
        me = q.pop_front();
        n_vec++;
        if ({redx, greenx, bluex} !== {me.r, me.g, me.b}) begin
          n_bad++;
          $display("FAIL rgb vec%0d: got %h want %h", me.id, {redx, greenx, bluex}, {me.r, me.g, me.b});
        end
        n_vec++;
        if ({blank_d, hc_d, vc_d} !== {me.bl, me.h, me.v}) begin
          n_bad++;
          $display("FAIL sync vec%0d: got blank_d=%b hc_d=%0d vc_d=%0d want %b %0d %0d",
                   me.id, blank_d, hc_d, vc_d, me.bl, me.h, me.v);
        end
        n_vec++;
        if ({e_redx, e_greenx, e_bluex} !== 12'h000) begin
          n_bad++;
          $display("FAIL empty_win vec%0d: got %h want 000", me.id, {e_redx, e_greenx, e_bluex});
        end
      end
    end
  end

  function automatic logic [95:0] mk(input logic [7:0] c, l, r, u, d, lu, ld, ru, rd, b, g, rr);
    return {c, l, r, u, d, lu, ld, ru, rd, b, g, rr};
  endfunction

  function automatic logic [95:0] uni(input logic [7:0] x);
    return mk(x, x, x, x, x, x, x, x, x, 8'h00, 8'h00, 8'h00);
  endfunction

  task automatic drive(input logic [9:0] h, v, input logic bl, input logic [95:0] d,
                       input logic mv, input logic [2:0] mr,
                       input logic [3:0] er, eg, eb);
    exp_t e;
    @(posedge pixel_clk);
    #1;
    hc = h; vc = v; blank = bl; dout = d; mode_req_valid = mv; mode_req = mr;
    e.cyc = cyc; e.id = vid; e.r = er; e.g = eg; e.b = eb; e.bl = bl; e.h = h; e.v = v;
    vid++;
    q.push_back(e);
  endtask

  task automatic px(input logic [9:0] h, v, input logic [95:0] d, input logic [3:0] er, eg, eb);
    drive(h, v, 1'b0, d, 1'b0, 3'd0, er, eg, eb);
  endtask

  // Frame-start cycle with a strobe: the request takes effect immediately.
  task automatic set_mode(input logic [2:0] m);
    drive(10'd0, 10'd0, 1'b1, '0, 1'b1, m, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [95:0] pix;

  initial begin
    pix = mk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h80, 8'hF0);
    #12;
    chk("reset_rgb", 16'({redx, greenx, bluex}), 16'h000);
    chk("reset_blank_d", 16'(blank_d), 16'h1);
    chk("reset_hcvc", 16'(hc_d | vc_d), 16'h0);
    chk("reset_mode", 16'(mode_active), 16'h0);
    @(negedge pixel_clk);
    reset = 1'b0;

    // PASS and window edges
    px(10'd100, 10'd100, pix, 4'hF, 4'h8, 4'h1);
    px(10'd259, 10'd100, pix, 4'hF, 4'h8, 4'h1);
    px(10'd260, 10'd100, pix, 4'h0, 4'h0, 4'h0);
    px(10'd99,  10'd100, pix, 4'h0, 4'h0, 4'h0);
    px(10'd150, 10'd214, pix, 4'hF, 4'h8, 4'h1);
    px(10'd150, 10'd215, pix, 4'h0, 4'h0, 4'h0);
    px(10'd150, 10'd99,  pix, 4'h0, 4'h0, 4'h0);
    drive(10'd150, 10'd150, 1'b1, pix, 1'b0, 3'd0, 4'h0, 4'h0, 4'h0);

    // EDGE
    set_mode(3'd4);
    px(10'd200, 10'd150, mk(8'h80, 8'h00, 8'hFF, 8'h80, 8'h80, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h0, 8'h0, 8'h0), 4'hF, 4'hF, 4'hF);
    px(10'd200, 10'd150, uni(8'h55), 4'h0, 4'h0, 4'h0);
    px(10'd200, 10'd150, mk(8'h80, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h0, 8'h0, 8'h0), 4'h4, 4'h4, 4'h4);

    // BLUR
    set_mode(3'd5);
    px(10'd200, 10'd150, uni(8'hFF), 4'hF, 4'hF, 4'hF);
    px(10'd200, 10'd150, uni(8'h10), 4'h1, 4'h1, 4'h1);
    px(10'd200, 10'd150, mk(8'hF0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0), 4'h3, 4'h3, 4'h3);

    // THR
    set_mode(3'd3);
    px(10'd200, 10'd150, uni(8'h80), 4'hF, 4'hF, 4'hF);
    px(10'd200, 10'd150, uni(8'h7F), 4'h0, 4'h0, 4'h0);

    // INV, GRAY, reserved
    set_mode(3'd2);
    px(10'd120, 10'd120, pix, 4'h0, 4'h7, 4'hE);
    set_mode(3'd1);
    px(10'd120, 10'd120, pix, 4'hA, 4'hA, 4'hA);
    set_mode(3'd6);
    px(10'd120, 10'd120, pix, 4'hF, 4'h8, 4'h1);

    // Frame-synchronous mode change
    set_mode(3'd0);
    drive(10'd50, 10'd5, 1'b0, pix, 1'b1, 3'd2, 4'h0, 4'h0, 4'h0);
    px(10'd100, 10'd100, pix, 4'hF, 4'h8, 4'h1);
    chk("mode_held_midframe", 16'(mode_active), 16'h0);
    drive(10'd0, 10'd0, 1'b1, '0, 1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    px(10'd100, 10'd100, pix, 4'h0, 4'h7, 4'hE);
    chk("mode_at_frame_start", 16'(mode_active), 16'h2);

    drive(10'd10, 10'd20, 1'b0, pix, 1'b1, 3'd4, 4'h0, 4'h0, 4'h0);
    drive(10'd11, 10'd20, 1'b0, pix, 1'b1, 3'd1, 4'h0, 4'h0, 4'h0);
    px(10'd150, 10'd150, pix, 4'h0, 4'h7, 4'hE);
    chk("mode_two_strobes_hold", 16'(mode_active), 16'h2);
    drive(10'd0, 10'd0, 1'b1, '0, 1'b0, 3'd0, 4'h0, 4'h0, 4'h0);
    px(10'd150, 10'd150, pix, 4'hA, 4'hA, 4'hA);
    chk("mode_last_write_wins", 16'(mode_active), 16'h1);

    // Asynchronous reset mid-line with non-zero pixels in flight
    px(10'd120, 10'd120, pix, 4'hA, 4'hA, 4'hA);
    px(10'd121, 10'd120, pix, 4'hA, 4'hA, 4'hA);
    #1 reset = 1'b1;
    #1;
    chk("midreset_rgb", 16'({redx, greenx, bluex}), 16'h000);
    chk("midreset_mode", 16'(mode_active), 16'h0);
    chk("midreset_blank_d", 16'(blank_d), 16'h1);
    q.delete();
    repeat (2) @(posedge pixel_clk);
    #2 reset = 1'b0;

    px(10'd100, 10'd100, pix, 4'hF, 4'h8, 4'h1);
    px(10'd101, 10'd214, pix, 4'hF, 4'h8, 4'h1);
    px(10'd100, 10'd215, pix, 4'h0, 4'h0, 4'h0);
    drive(10'd300, 10'd300, 1'b1, '0, 1'b0, 3'd0, 4'h0, 4'h0, 4'h0);

    repeat (4) @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("scoreboard_drained", 16'(q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
